tlx_vc1_cmd_xmit: RTL and testbench

- TLX-side transmitter for the VC1 command channel and DCP1 command-data channel toward the AFU.
- Accepts packed host commands and 64B data beats from the OCSE4 driver logic.
- Issues commands on tlx_afu_vc1_* only while AFU-granted VC1 credits are available.
- Serves afu_tlx_dcp1_rd_req pulls from an internal data FIFO.

---
 rtl/tlx_vc1_pkg.sv | 49 ++++
 rtl/tlx_sync_fifo.sv | 55 +++++
 rtl/tlx_vc1_cmd_xmit.sv | 193 +++++++++++++++++++
 tb/tb_tlx_vc1_cmd_xmit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlx_vc1_pkg.sv
// rtl/tlx_vc1_pkg.sv - shared types, encodings and helpers for the VC1 command transmitter
package tlx_vc1_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] afutag;
    logic [15:0] capptag;
    logic [63:0] pa;
    logic [1:0]  dl;
    logic [1:0]  dp;
    logic [63:0] be;
    logic [2:0]  pl;
    logic        endian;
    logic        co;
    logic        os;
    logic [3:0]  cmdflag;
    logic [7:0]  mad;
  } vc1_cmd_t;

  typedef enum logic [1:0] {ST_INIT, ST_LOAD, ST_RUN} tx_state_e;

  localparam logic [2:0] RD_CNT_1 = 3'b001;
  localparam logic [2:0] RD_CNT_2 = 3'b010;
  localparam logic [2:0] RD_CNT_4 = 3'b100;
  localparam logic [2:0] RD_CNT_8 = 3'b000;

  localparam int ERR_CREDIT_OVF     = 0;
  localparam int ERR_DATA_UNDERRUN  = 1;
  localparam int ERR_RD_CNT_ILLEGAL = 2;

  // Unknown codes are served as a single beat so the AFU still gets data.
  function automatic logic [3:0] rd_cnt_beats(input logic [2:0] code);
    case (code)
      RD_CNT_1: return 4'd1;
      RD_CNT_2: return 4'd2;
      RD_CNT_4: return 4'd4;
      RD_CNT_8: return 4'd8;
      default:  return 4'd1;
    endcase
  endfunction

  function automatic logic rd_cnt_illegal(input logic [2:0] code);
    case (code)
      RD_CNT_1, RD_CNT_2, RD_CNT_4, RD_CNT_8: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/tlx_sync_fifo.sv
// rtl/tlx_sync_fifo.sv - single-clock FIFO, no read bypass, push-on-full allowed with a pop
module tlx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy tracking; reset discards everything buffered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tlx_vc1_cmd_xmit.sv
// rtl/tlx_vc1_cmd_xmit.sv - VC1 command / DCP1 data transmitter toward the AFU (debug counters under TLX_VC1_DBG_CNT_EN)
module tlx_vc1_cmd_xmit
  import tlx_vc1_pkg::*;
#(
  parameter int DATA_DEPTH = 16,
  parameter int CRED_W     = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_in_valid,
  output logic              cmd_in_ready,
  input  vc1_cmd_t          cmd_in_payload,
  input  logic              dat_in_valid,
  output logic              dat_in_ready,
  input  logic [511:0]      dat_in_bus,
  input  logic              dat_in_bdi,
  input  logic [CRED_W-1:0] afu_tlx_vc1_initial_credit,
  input  logic              afu_tlx_vc1_credit,
  output logic              tlx_afu_vc1_valid,
  output logic [7:0]        tlx_afu_vc1_opcode,
  output logic [15:0]       tlx_afu_vc1_afutag,
  output logic [15:0]       tlx_afu_vc1_capptag,
  output logic [63:0]       tlx_afu_vc1_pa,
  output logic [1:0]        tlx_afu_vc1_dl,
  output logic [1:0]        tlx_afu_vc1_dp,
  output logic [63:0]       tlx_afu_vc1_be,
  output logic [2:0]        tlx_afu_vc1_pl,
  output logic              tlx_afu_vc1_endian,
  output logic              tlx_afu_vc1_co,
  output logic              tlx_afu_vc1_os,
  output logic [3:0]        tlx_afu_vc1_cmdflag,
  output logic [7:0]        tlx_afu_vc1_mad,
  input  logic              afu_tlx_dcp1_rd_req,
  input  logic [2:0]        afu_tlx_dcp1_rd_cnt,
  output logic              tlx_afu_dcp1_data_valid,
  output logic [511:0]      tlx_afu_dcp1_data_bus,
  output logic              tlx_afu_dcp1_data_bdi,
  output logic [2:0]        err_sticky
`ifdef TLX_VC1_DBG_CNT_EN
  ,
  output logic [CRED_W-1:0] dbg_credit_cnt,
  output logic [CRED_W-1:0] dbg_credit_min,
  output logic [31:0]       dbg_cmd_cnt
`endif
);

  tx_state_e         state_q;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [CRED_W:0]   cred_base, cred_sum;
  logic              cred_ovf;
  logic              cmd_accept;
  logic              cmd_valid_q;
  vc1_cmd_t          cmd_q;

  logic [4:0]        pending_q, pending_d;
  logic [5:0]        pend_sum;
  logic              pend_ovf, underrun;
  logic [3:0]        rd_beats;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DATA_DEPTH):0] fifo_count;
  logic [512:0]      fifo_rdata;

  logic              data_valid_q;
  logic [511:0]      data_bus_q;
  logic              data_bdi_q;
  logic [2:0]        err_q, err_set;

  assign cmd_in_ready = (state_q == ST_RUN) && (credit_q != '0);
  assign cmd_accept   = cmd_in_valid && cmd_in_ready;
  // Held off during INIT so every output reads zero while in and just out of reset.
  assign dat_in_ready = !fifo_full && (state_q != ST_INIT);
  assign fifo_push    = dat_in_valid && dat_in_ready;
  assign fifo_pop     = (pending_q != '0) && (fifo_count != '0);
  assign underrun     = (pending_q != '0) && fifo_empty;
  assign rd_beats     = rd_cnt_beats(afu_tlx_dcp1_rd_cnt);

  // Credit arithmetic: LOAD folds the initial grant onto returns seen so far; overflow saturates.
  always_comb begin
    cred_base = {1'b0, credit_q};
    if (state_q == ST_LOAD) cred_base = {1'b0, credit_q} + {1'b0, afu_tlx_vc1_initial_credit};
    cred_sum = cred_base - {{CRED_W{1'b0}}, cmd_accept} + {{CRED_W{1'b0}}, afu_tlx_vc1_credit};
    cred_ovf = cred_sum[CRED_W];
    credit_d = cred_ovf ? '1 : cred_sum[CRED_W-1:0];
  end

  // Outstanding-beat bookkeeping: add decoded request, retire one per pop, saturate at 31.
  always_comb begin
    pend_sum  = {1'b0, pending_q}
              + (afu_tlx_dcp1_rd_req ? {2'b00, rd_beats} : 6'd0)
              - {5'd0, fifo_pop};
    pend_ovf  = pend_sum[5];
    pending_d = pend_ovf ? 5'd31 : pend_sum[4:0];
    err_set                     = '0;
    err_set[ERR_CREDIT_OVF]     = cred_ovf;
    err_set[ERR_DATA_UNDERRUN]  = underrun || pend_ovf;
    err_set[ERR_RD_CNT_ILLEGAL] = afu_tlx_dcp1_rd_req && rd_cnt_illegal(afu_tlx_dcp1_rd_cnt);
  end

  // Control FSM with credit counter and registered command outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      credit_q    <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
    end else begin
      credit_q    <= credit_d;
      cmd_valid_q <= cmd_accept;
      if (cmd_accept) cmd_q <= cmd_in_payload;
      case (state_q)
        ST_INIT: state_q <= ST_LOAD;
        ST_LOAD: state_q <= ST_RUN;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Data return path: registered beat output, pending counter and sticky errors.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      data_valid_q <= 1'b0;
      data_bus_q   <= '0;
      data_bdi_q   <= 1'b0;
      err_q        <= '0;
    end else begin
      pending_q    <= pending_d;
      data_valid_q <= fifo_pop;
      if (fifo_pop) begin
        data_bus_q <= fifo_rdata[511:0];
        data_bdi_q <= fifo_rdata[512];
      end
      err_q <= err_q | err_set;
    end
  end

  tlx_sync_fifo #(
    .WIDTH (513),
    .DEPTH (DATA_DEPTH)
  ) u_data_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .wdata_i ({dat_in_bdi, dat_in_bus}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tlx_afu_vc1_valid       = cmd_valid_q;
  assign tlx_afu_vc1_opcode      = cmd_q.opcode;
  assign tlx_afu_vc1_afutag      = cmd_q.afutag;
  assign tlx_afu_vc1_capptag     = cmd_q.capptag;
  assign tlx_afu_vc1_pa          = cmd_q.pa;
  assign tlx_afu_vc1_dl          = cmd_q.dl;
  assign tlx_afu_vc1_dp          = cmd_q.dp;
  assign tlx_afu_vc1_be          = cmd_q.be;
  assign tlx_afu_vc1_pl          = cmd_q.pl;
  assign tlx_afu_vc1_endian      = cmd_q.endian;
  assign tlx_afu_vc1_co          = cmd_q.co;
  assign tlx_afu_vc1_os          = cmd_q.os;
  assign tlx_afu_vc1_cmdflag     = cmd_q.cmdflag;
  assign tlx_afu_vc1_mad         = cmd_q.mad;
  assign tlx_afu_dcp1_data_valid = data_valid_q;
  assign tlx_afu_dcp1_data_bus   = data_bus_q;
  assign tlx_afu_dcp1_data_bdi   = data_bdi_q;
  assign err_sticky              = err_q;

`ifdef TLX_VC1_DBG_CNT_EN
  logic [CRED_W-1:0] dbg_min_q;
  logic [31:0]       dbg_cmd_q;

  // Credit low-water mark (restarts at LOAD) and wrapping issued-command count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dbg_min_q <= '1;
      dbg_cmd_q <= '0;
    end else begin
      if (state_q == ST_LOAD) dbg_min_q <= credit_d;
      else if ((state_q == ST_RUN) && (credit_d < dbg_min_q)) dbg_min_q <= credit_d;
      if (cmd_accept) dbg_cmd_q <= dbg_cmd_q + 32'd1;
    end
  end

  assign dbg_credit_cnt = credit_q;
  assign dbg_credit_min = dbg_min_q;
  assign dbg_cmd_cnt    = dbg_cmd_q;
`endif

endmodule

// File: tb/tb_tlx_vc1_cmd_xmit.sv
// tb/tb_tlx_vc1_cmd_xmit.sv - directed, table-driven bench for tlx_vc1_cmd_xmit
module tb_tlx_vc1_cmd_xmit;
  import tlx_vc1_pkg::*;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_in_valid = 1'b0;
  logic         cmd_in_ready;
  vc1_cmd_t     cmd_in_payload = '0;
  logic         dat_in_valid = 1'b0;
  logic         dat_in_ready;
  logic [511:0] dat_in_bus = '0;
  logic         dat_in_bdi = 1'b0;
  logic [6:0]   afu_tlx_vc1_initial_credit = '0;
  logic         afu_tlx_vc1_credit = 1'b0;
  logic         tlx_afu_vc1_valid;
  logic [7:0]   tlx_afu_vc1_opcode;
  logic [15:0]  tlx_afu_vc1_afutag;
  logic [15:0]  tlx_afu_vc1_capptag;
  logic [63:0]  tlx_afu_vc1_pa;
  logic [1:0]   tlx_afu_vc1_dl;
  logic [1:0]   tlx_afu_vc1_dp;
  logic [63:0]  tlx_afu_vc1_be;
  logic [2:0]   tlx_afu_vc1_pl;
  logic         tlx_afu_vc1_endian;
  logic         tlx_afu_vc1_co;
  logic         tlx_afu_vc1_os;
  logic [3:0]   tlx_afu_vc1_cmdflag;
  logic [7:0]   tlx_afu_vc1_mad;
  logic         afu_tlx_dcp1_rd_req = 1'b0;
  logic [2:0]   afu_tlx_dcp1_rd_cnt = '0;
  logic         tlx_afu_dcp1_data_valid;
  logic [511:0] tlx_afu_dcp1_data_bus;
  logic         tlx_afu_dcp1_data_bdi;
  logic [2:0]   err_sticky;

  int total = 0;
  int bad   = 0;

  tlx_vc1_cmd_xmit #(.DATA_DEPTH(16), .CRED_W(7)) dut (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .cmd_in_valid               (cmd_in_valid),
    .cmd_in_ready               (cmd_in_ready),
    .cmd_in_payload             (cmd_in_payload),
    .dat_in_valid               (dat_in_valid),
    .dat_in_ready               (dat_in_ready),
    .dat_in_bus                 (dat_in_bus),
    .dat_in_bdi                 (dat_in_bdi),
    .afu_tlx_vc1_initial_credit (afu_tlx_vc1_initial_credit),
    .afu_tlx_vc1_credit         (afu_tlx_vc1_credit),
    .tlx_afu_vc1_valid          (tlx_afu_vc1_valid),
    .tlx_afu_vc1_opcode         (tlx_afu_vc1_opcode),
    .tlx_afu_vc1_afutag         (tlx_afu_vc1_afutag),
    .tlx_afu_vc1_capptag        (tlx_afu_vc1_capptag),
    .tlx_afu_vc1_pa             (tlx_afu_vc1_pa),
    .tlx_afu_vc1_dl             (tlx_afu_vc1_dl),
    .tlx_afu_vc1_dp             (tlx_afu_vc1_dp),
    .tlx_afu_vc1_be             (tlx_afu_vc1_be),
    .tlx_afu_vc1_pl             (tlx_afu_vc1_pl),
    .tlx_afu_vc1_endian         (tlx_afu_vc1_endian),
    .tlx_afu_vc1_co             (tlx_afu_vc1_co),
    .tlx_afu_vc1_os             (tlx_afu_vc1_os),
    .tlx_afu_vc1_cmdflag        (tlx_afu_vc1_cmdflag),
    .tlx_afu_vc1_mad            (tlx_afu_vc1_mad),
    .afu_tlx_dcp1_rd_req        (afu_tlx_dcp1_rd_req),
    .afu_tlx_dcp1_rd_cnt        (afu_tlx_dcp1_rd_cnt),
    .tlx_afu_dcp1_data_valid    (tlx_afu_dcp1_data_valid),
    .tlx_afu_dcp1_data_bus      (tlx_afu_dcp1_data_bus),
    .tlx_afu_dcp1_data_bdi      (tlx_afu_dcp1_data_bdi),
    .err_sticky                 (err_sticky)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] code;
    int         beats;
    logic       err2;
  } rdvec_t;

  rdvec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{cmd_in_ready, dat_in_ready, tlx_afu_vc1_valid, tlx_afu_vc1_opcode, tlx_afu_vc1_afutag,
             tlx_afu_vc1_capptag, tlx_afu_vc1_pa, tlx_afu_vc1_dl, tlx_afu_vc1_dp, tlx_afu_vc1_be,
             tlx_afu_vc1_pl, tlx_afu_vc1_endian, tlx_afu_vc1_co, tlx_afu_vc1_os, tlx_afu_vc1_cmdflag,
             tlx_afu_vc1_mad, tlx_afu_dcp1_data_valid, tlx_afu_dcp1_data_bus, tlx_afu_dcp1_data_bdi,
             err_sticky};
  endfunction

  function automatic vc1_cmd_t mk_cmd(input int i);
    vc1_cmd_t c;
    c         = '0;
    c.opcode  = 8'h20 + 8'(i);
    c.afutag  = 16'hA000 + 16'(i);
    c.capptag = 16'h5500 + 16'(i);
    c.pa      = 64'hDEAD_0000_0000_0000 | (64'(i) << 12);
    c.be      = ~64'(i);
    c.dl      = 2'(i);
    c.cmdflag = 4'(i + 1);
    c.mad     = 8'hC0 + 8'(i);
    return c;
  endfunction

  function automatic logic [511:0] beat(input int v, input int i);
    return {8{64'(v * 256 + i)}};
  endfunction

  task automatic do_reset(input logic [6:0] init_cred);
    reset_n = 1'b0;
    cmd_in_valid = 1'b0;
    dat_in_valid = 1'b0;
    afu_tlx_vc1_credit = 1'b0;
    afu_tlx_dcp1_rd_req = 1'b0;
    afu_tlx_dcp1_rd_cnt = '0;
    afu_tlx_vc1_initial_credit = init_cred;
    tick();
    tick();
    chk("rst_outs_zero", any_out(), 1'b0);
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic push_beat(input logic [511:0] d, input logic b);
    chk("push_ready", dat_in_ready, 1'b1);
    dat_in_valid = 1'b1;
    dat_in_bus   = d;
    dat_in_bdi   = b;
    tick();
    dat_in_valid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] code);
    afu_tlx_dcp1_rd_req = 1'b1;
    afu_tlx_dcp1_rd_cnt = code;
    tick();
    afu_tlx_dcp1_rd_req = 1'b0;
  endtask

  initial begin
    int exp_cred;
    int k;
    int first_c;
    int last_c;
    int n;
    logic acc;

    vecs[0] = '{3'b001, 1, 1'b0};
    vecs[1] = '{3'b010, 2, 1'b0};
    vecs[2] = '{3'b100, 4, 1'b0};
    vecs[3] = '{3'b000, 8, 1'b0};
    vecs[4] = '{3'b011, 1, 1'b1};
    vecs[5] = '{3'b101, 1, 1'b1};
    vecs[6] = '{3'b110, 1, 1'b1};
    vecs[7] = '{3'b111, 1, 1'b1};

    // credit 3, five back-to-back commands
    do_reset(7'd3);
    exp_cred = 3;
    for (int i = 0; i < 5; i++) begin
      cmd_in_valid   = 1'b1;
      cmd_in_payload = mk_cmd(i);
      acc = (exp_cred != 0);
      chk("cmd_ready", cmd_in_ready, acc);
      tick();
      chk("vc1_valid", tlx_afu_vc1_valid, acc);
      if (acc) begin
        chk("vc1_opcode", tlx_afu_vc1_opcode, mk_cmd(i).opcode);
        chk("vc1_pa", tlx_afu_vc1_pa, mk_cmd(i).pa);
        chk("vc1_be", tlx_afu_vc1_be, mk_cmd(i).be);
        exp_cred--;
      end
    end
    cmd_in_valid = 1'b0;
    chk("ready_exhausted", cmd_in_ready, 1'b0);
    chk("fields_hold", tlx_afu_vc1_afutag, mk_cmd(2).afutag);
    afu_tlx_vc1_credit = 1'b1;
    tick();
    afu_tlx_vc1_credit = 1'b0;
    chk("ready_after_return", cmd_in_ready, 1'b1);
    cmd_in_valid   = 1'b1;
    cmd_in_payload = mk_cmd(3);
    tick();
    cmd_in_valid = 1'b0;
    chk("fourth_valid", tlx_afu_vc1_valid, 1'b1);
    chk("fourth_afutag", tlx_afu_vc1_afutag, mk_cmd(3).afutag);
    chk("fourth_mad", tlx_afu_vc1_mad, mk_cmd(3).mad);
    tick();
    chk("valid_one_cycle", tlx_afu_vc1_valid, 1'b0);
    chk("fields_hold2", tlx_afu_vc1_capptag, mk_cmd(3).capptag);

    // credit 1 with accept coincident with a return
    do_reset(7'd1);
    cmd_in_valid       = 1'b1;
    cmd_in_payload     = mk_cmd(7);
    afu_tlx_vc1_credit = 1'b1;
    tick();
    afu_tlx_vc1_credit = 1'b0;
    chk("net0_valid", tlx_afu_vc1_valid, 1'b1);
    chk("net0_ready", cmd_in_ready, 1'b1);
    tick();
    cmd_in_valid = 1'b0;
    chk("last_credit_valid", tlx_afu_vc1_valid, 1'b1);
    chk("last_credit_ready", cmd_in_ready, 1'b0);

    // credit saturation at 127
    do_reset(7'h7F);
    chk("no_err_before", err_sticky, 3'b000);
    afu_tlx_vc1_credit = 1'b1;
    tick();
    afu_tlx_vc1_credit = 1'b0;
    chk("cred_ovf_err", err_sticky, 3'b001);
    cmd_in_valid = 1'b1;
    n = 0;
    while (cmd_in_ready && n < 200) begin
      tick();
      n++;
    end
    cmd_in_valid = 1'b0;
    chk("sat_credit_count", 32'(n), 32'd127);

    // rd_cnt decode table
    for (int v = 0; v < 8; v++) begin
      do_reset(7'd4);
      for (int i = 0; i < 8; i++) push_beat(beat(v, i), i == 5);
      rd(vecs[v].code);
      k = 0;
      first_c = -1;
      last_c = -1;
      for (int c = 0; c < 14; c++) begin
        tick();
        if (tlx_afu_dcp1_data_valid) begin
          chk("beat_data", tlx_afu_dcp1_data_bus, beat(v, k));
          chk("beat_bdi", tlx_afu_dcp1_data_bdi, k == 5);
          if (first_c < 0) first_c = c;
          last_c = c;
          k++;
        end
      end
      chk("beat_count", 32'(k), 32'(vecs[v].beats));
      chk("first_latency", 32'(first_c), 32'd0);
      chk("back_to_back", 32'(last_c - first_c + 1), 32'(vecs[v].beats));
      chk("rd_err", err_sticky, {vecs[v].err2, 2'b00});
    end

    // underrun: two beats buffered, three requested
    do_reset(7'd4);
    push_beat(beat(9, 0), 1'b0);
    push_beat(beat(9, 1), 1'b1);
    rd(3'b010);
    tick();
    chk("ur_b0_valid", tlx_afu_dcp1_data_valid, 1'b1);
    chk("ur_b0_data", tlx_afu_dcp1_data_bus, beat(9, 0));
    afu_tlx_dcp1_rd_req = 1'b1;
    afu_tlx_dcp1_rd_cnt = 3'b001;
    tick();
    afu_tlx_dcp1_rd_req = 1'b0;
    chk("ur_b1_valid", tlx_afu_dcp1_data_valid, 1'b1);
    chk("ur_b1_bdi", tlx_afu_dcp1_data_bdi, 1'b1);
    tick();
    chk("ur_empty_valid", tlx_afu_dcp1_data_valid, 1'b0);
    chk("ur_err", err_sticky, 3'b010);
    tick();
    chk("ur_empty_valid2", tlx_afu_dcp1_data_valid, 1'b0);
    push_beat(beat(9, 2), 1'b0);
    chk("ur_no_bypass", tlx_afu_dcp1_data_valid, 1'b0);
    tick();
    chk("ur_b2_valid", tlx_afu_dcp1_data_valid, 1'b1);
    chk("ur_b2_data", tlx_afu_dcp1_data_bus, beat(9, 2));
    tick();
    chk("ur_done", tlx_afu_dcp1_data_valid, 1'b0);

    // reset in the middle of a burst
    do_reset(7'd4);
    for (int i = 0; i < 8; i++) push_beat(beat(11, i), 1'b0);
    rd(3'b000);
    tick();
    tick();
    chk("mid_burst_active", tlx_afu_dcp1_data_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_zero", any_out(), 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_ready", dat_in_ready, 1'b1);
    rd(3'b001);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (tlx_afu_dcp1_data_valid) k++;
    end
    chk("post_rst_no_beats", 32'(k), 32'd0);
    chk("post_rst_empty_err", err_sticky, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
